// File: rtl/vga_frame_scheduler.sv
// -----------------------------------------------------------------------------
// vga_frame_scheduler
//
// Vertical sequencer for a 640x480 VGA frame plus arbiter for the single-port
// synchronous frame-buffer RAM. Lines are counted from the horizontal
// generator's linetic pulse. Display scan-out owns the RAM whenever it needs a
// pixel. A one-entry write buffer drains into any cycle without a fetch.
//
// Parameters
//   PIXW        pixel data width
//   AW          frame-buffer address width (307200 words used)
//
// Ports
//   inputclk    pixel clock (25 MHz), shared with the horizontal generator
//   reset_b     asynchronous reset, active HIGH despite the name
//   linetic     one-cycle pulse on the last clock of each 800-clock line
//   Hdisplay    high during the 640 active pixels of a line
//   wr_valid    writer offers a pixel (wr_addr / wr_data)
//   wr_ready    write buffer is empty and can accept
//   wr_err      one-cycle pulse when a buffered write is out of range and dropped
//   vsync_n     vertical sync, active low (lines 0-1)
//   Vdisplay    current line is an active display line (lines 35-514)
//   frame_tic   one-cycle pulse on the last clock of the frame
//   mem_addr    RAM address (pixel fetch address or draining write address)
//   mem_we      RAM write enable
//   mem_wdata   RAM write data
//   pixel_valid RAM read data is a display pixel this cycle
// -----------------------------------------------------------------------------
module vga_frame_scheduler #(
    parameter int PIXW = 8,
    parameter int AW   = 19
) (
    input  logic            inputclk,
    input  logic            reset_b,
    input  logic            linetic,
    input  logic            Hdisplay,
    input  logic            wr_valid,
    input  logic [AW-1:0]   wr_addr,
    input  logic [PIXW-1:0] wr_data,
    output logic            wr_ready,
    output logic            wr_err,
    output logic            vsync_n,
    output logic            Vdisplay,
    output logic            frame_tic,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_we,
    output logic [PIXW-1:0] mem_wdata,
    output logic            pixel_valid
);

    localparam logic [9:0]    LAST_LINE  = 10'd524;
    localparam logic [9:0]    VSYNC_END  = 10'd2;
    localparam logic [9:0]    VDISP_FROM = 10'd35;
    localparam logic [9:0]    VDISP_TO   = 10'd515;
    localparam logic [AW-1:0] FB_WORDS   = AW'(307200);

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    buf_state_t      r_state;
    buf_state_t      w_next_state;
    logic [9:0]      r_vcount;
    logic [AW-1:0]   r_pix_addr;
    logic [AW-1:0]   r_buf_addr;
    logic [PIXW-1:0] r_buf_data;
    logic            r_pixel_valid;
    logic            w_fetch;
    logic            w_accept;

    // ------------------------------------------------------------------
    // Vertical decodes: combinational from the registered line count.
    // ------------------------------------------------------------------
    assign vsync_n   = ~(r_vcount < VSYNC_END);
    assign Vdisplay  = (r_vcount >= VDISP_FROM) & (r_vcount < VDISP_TO);
    assign frame_tic = linetic & (r_vcount == LAST_LINE);
    assign w_fetch   = Hdisplay & Vdisplay;

    assign wr_ready    = (r_state == BUF_EMPTY);
    assign pixel_valid = r_pixel_valid;

    // ------------------------------------------------------------------
    // Line counter, scan-out address and read-valid pipeline.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours regardless of block order.
    always_ff @(posedge inputclk or posedge reset_b) begin
        if (reset_b) begin
            r_vcount      <= '0;
            r_pix_addr    <= '0;
            r_pixel_valid <= 1'b0;
        end else begin
            r_pixel_valid <= w_fetch;
            if (linetic) begin
                r_vcount <= (r_vcount == LAST_LINE) ? '0 : r_vcount + 10'd1;
            end
            // linetic and Hdisplay never coincide, so clear and increment
            // are mutually exclusive.
            if (frame_tic) begin
                r_pix_addr <= '0;
            end else if (w_fetch) begin
                r_pix_addr <= r_pix_addr + AW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Write buffer: state register (validity) and payload.
    // ------------------------------------------------------------------
    always_ff @(posedge inputclk or posedge reset_b) begin
        if (reset_b) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the payload carries no reset; its contents only matter while
    // r_state says FULL, and reset forces EMPTY.
    always_ff @(posedge inputclk) begin
        if (w_accept) begin
            r_buf_addr <= wr_addr;
            r_buf_data <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Next state and RAM port mux. Scan-out always wins; a full buffer
    // leaves in the first non-fetch cycle, either written or dropped.
    // ------------------------------------------------------------------
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned (which would infer a latch).
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        wr_err       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = r_pix_addr;
        mem_wdata    = r_buf_data;
        case (r_state)
            BUF_EMPTY: begin
                if (wr_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (!w_fetch) begin
                    w_next_state = BUF_EMPTY;
                    if (r_buf_addr < FB_WORDS) begin
                        mem_we   = 1'b1;
                        mem_addr = r_buf_addr;
                    end else begin
                        wr_err = 1'b1;
                    end
                end
            end
            default: w_next_state = BUF_EMPTY;
        endcase
    end

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for vga_frame_scheduler. Every cycle is checked against a
// line/pixel/queue reference model; directed vectors and sequences cover the
// blanking write, out-of-range write, write stalled by an active line and a
// reset with the buffer full. Frames use compressed lines (8 clocks, 4 active)
// since the line counter only sees linetic; one full 800-clock line is used
// for the active-pixel write case.
// -----------------------------------------------------------------------------
module tb_vga_frame_scheduler;

    localparam int PIXW     = 8;
    localparam int AW       = 19;
    localparam int FB_WORDS = 640 * 480;
    localparam int LINES    = 525;
    localparam int S_LINE   = 8;   // compressed line length
    localparam int S_HS     = 2;   // first active clock in compressed line
    localparam int S_HACT   = 4;   // active clocks per compressed line

    logic            inputclk = 1'b0;
    logic            reset_b;
    logic            linetic, Hdisplay, wr_valid;
    logic [AW-1:0]   wr_addr;
    logic [PIXW-1:0] wr_data;
    logic            wr_ready, wr_err, vsync_n, Vdisplay, frame_tic;
    logic [AW-1:0]   mem_addr;
    logic            mem_we;
    logic [PIXW-1:0] mem_wdata;
    logic            pixel_valid;

    vga_frame_scheduler #(.PIXW(PIXW), .AW(AW)) dut (
        .inputclk    (inputclk),
        .reset_b     (reset_b),
        .linetic     (linetic),
        .Hdisplay    (Hdisplay),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .wr_err      (wr_err),
        .vsync_n     (vsync_n),
        .Vdisplay    (Vdisplay),
        .frame_tic   (frame_tic),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .pixel_valid (pixel_valid)
    );

    always #5 inputclk = ~inputclk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0]   addr;
        logic [PIXW-1:0] data;
    } wr_t;

    int  m_line;     // current line number
    int  m_pix;      // pixels fetched so far this frame
    bit  m_pv;       // a pixel was fetched last cycle
    wr_t m_q[$];     // pending write (at most one)

    // values sampled from the DUT in the last tick
    logic            s_wr_ready, s_wr_err, s_vsync_n, s_vdisplay, s_frame_tic;
    logic            s_mem_we, s_pixel_valid;
    logic [AW-1:0]   s_mem_addr;
    logic [PIXW-1:0] s_mem_wdata;

    task automatic model_reset();
        m_line = 0;
        m_pix  = 0;
        m_pv   = 0;
        m_q.delete();
    endtask

    // Apply one cycle of inputs (called at posedge+1), compare all outputs
    // with the model at the falling edge, advance the model, return at posedge+1.
    task automatic tick(input logic lt, input logic hd, input logic wv,
                        input logic [AW-1:0] wa, input logic [PIXW-1:0] wd);
        bit              active, fetch, full, drain, drop;
        logic [AW-1:0]   e_addr;
        logic [PIXW-1:0] e_wd, a_wd;
        wr_t             w;
        linetic  = lt;
        Hdisplay = hd;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        @(negedge inputclk);
        s_wr_ready    = wr_ready;
        s_wr_err      = wr_err;
        s_vsync_n     = vsync_n;
        s_vdisplay    = Vdisplay;
        s_frame_tic   = frame_tic;
        s_mem_we      = mem_we;
        s_pixel_valid = pixel_valid;
        s_mem_addr    = mem_addr;
        s_mem_wdata   = mem_wdata;

        active = (m_line >= 35) && (m_line < 515);
        fetch  = hd && active;
        full   = (m_q.size() != 0);
        drain  = full && !fetch && (int'(m_q[0].addr) < FB_WORDS);
        drop   = full && !fetch && (int'(m_q[0].addr) >= FB_WORDS);
        e_addr = drain ? m_q[0].addr : AW'(m_pix);
        e_wd   = drain ? m_q[0].data : '0;
        a_wd   = drain ? s_mem_wdata : '0;
        check("model_outputs",
              {s_wr_ready, s_wr_err, s_vsync_n, s_vdisplay, s_frame_tic, s_mem_we,
               s_pixel_valid, s_mem_addr, a_wd},
              {!full, drop, !(m_line < 2), active, lt && (m_line == LINES - 1), drain,
               m_pv, e_addr, e_wd});

        m_pv = fetch;
        if (full && !fetch) begin
            void'(m_q.pop_front());
        end else if (!full && wv) begin
            w.addr = wa;
            w.data = wd;
            m_q.push_back(w);
        end
        if (fetch) m_pix++;
        if (lt) begin
            if (m_line == LINES - 1) begin
                m_line = 0;
                m_pix  = 0;
            end else begin
                m_line++;
            end
        end
        cyc++;
        @(posedge inputclk);
        #1;
    endtask

    // Assert reset mid-cycle (called at posedge+1), check reset outputs,
    // hold across an edge, then release.
    task automatic do_reset(input logic hd_hold);
        linetic  = 1'b0;
        Hdisplay = hd_hold;
        wr_valid = 1'b0;
        reset_b  = 1'b1;
        #2;
        check("reset_outputs",
              {wr_ready, wr_err, vsync_n, Vdisplay, frame_tic, mem_we, pixel_valid, mem_addr},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {AW{1'b0}}});
        @(posedge inputclk);
        #1;
        reset_b = 1'b0;
        model_reset();
    endtask

    task automatic adv_lines(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, 1'b0, 1'b0, '0, '0);
            tick(1'b0, 1'b0, 1'b0, '0, '0);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic            lt, wv;
        logic [AW-1:0]   wa;
        logic [PIXW-1:0] wd;
        logic            e_rdy, e_err, e_we, e_vs;
        logic [AW-1:0]   e_addr;
        logic [PIXW-1:0] e_wd;   // compared only when e_we
    } vec_t;

    vec_t vecs[14];

    initial begin
        int bad, we_seen, pv_cnt, vs_lines, vd_lines, fstart;
        int tics[$];
        logic [AW-1:0]   ra;
        logic [PIXW-1:0] rd;
        logic            rv;

        //           lt  wv  wa          wd      rdy err we  vs  addr        wd
        vecs[0]  = '{1'b0, 1'b1, AW'(1234),   8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, AW'(0),      8'h00};
        vecs[1]  = '{1'b0, 1'b0, AW'(0),      8'h00, 1'b0, 1'b0, 1'b1, 1'b1, AW'(1234),   8'hA5};
        vecs[2]  = '{1'b0, 1'b0, AW'(0),      8'h00, 1'b1, 1'b0, 1'b0, 1'b1, AW'(0),      8'h00};
        vecs[3]  = '{1'b0, 1'b1, AW'(307200), 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, AW'(0),      8'h00};
        vecs[4]  = '{1'b0, 1'b0, AW'(0),      8'h00, 1'b0, 1'b1, 1'b0, 1'b1, AW'(0),      8'h00};
        vecs[5]  = '{1'b0, 1'b0, AW'(0),      8'h00, 1'b1, 1'b0, 1'b0, 1'b1, AW'(0),      8'h00};
        vecs[6]  = '{1'b0, 1'b1, AW'(5),      8'h11, 1'b1, 1'b0, 1'b0, 1'b1, AW'(0),      8'h00};
        vecs[7]  = '{1'b0, 1'b1, AW'(6),      8'h22, 1'b0, 1'b0, 1'b1, 1'b1, AW'(5),      8'h11};
        vecs[8]  = '{1'b0, 1'b1, AW'(6),      8'h22, 1'b1, 1'b0, 1'b0, 1'b1, AW'(0),      8'h00};
        vecs[9]  = '{1'b0, 1'b0, AW'(0),      8'h00, 1'b0, 1'b0, 1'b1, 1'b1, AW'(6),      8'h22};
        vecs[10] = '{1'b1, 1'b0, AW'(0),      8'h00, 1'b1, 1'b0, 1'b0, 1'b1, AW'(0),      8'h00};
        vecs[11] = '{1'b0, 1'b1, AW'(307199), 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, AW'(0),      8'h00};
        vecs[12] = '{1'b0, 1'b0, AW'(0),      8'h00, 1'b0, 1'b0, 1'b1, 1'b1, AW'(307199), 8'hFF};
        vecs[13] = '{1'b0, 1'b0, AW'(0),      8'h00, 1'b1, 1'b0, 1'b0, 1'b1, AW'(0),      8'h00};

        reset_b  = 1'b0;
        linetic  = 1'b0;
        Hdisplay = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        @(posedge inputclk);
        #1;
        do_reset(1'b0);

        // ---- writes during blanking (line 10), drop, back-to-back, top address
        adv_lines(10);
        for (int i = 0; i < 14; i++) begin
            tick(vecs[i].lt, 1'b0, vecs[i].wv, vecs[i].wa, vecs[i].wd);
            check($sformatf("vec%0d", i),
                  {s_wr_ready, s_wr_err, s_mem_we, s_vsync_n, s_mem_addr,
                   (vecs[i].e_we ? s_mem_wdata : 8'h00)},
                  {vecs[i].e_rdy, vecs[i].e_err, vecs[i].e_we, vecs[i].e_vs, vecs[i].e_addr,
                   vecs[i].e_wd});
        end

        // ---- full 800-clock line at line 100, write accepted at clock 200
        adv_lines(100 - 11);
        bad = 0;
        we_seen = 0;
        for (int c = 0; c < 800; c++) begin
            tick(c == 799, (c >= 144) && (c < 784), c == 200, AW'(4321), 8'h5A);
            if ((c >= 144) && (c < 784) && (int'(s_mem_addr) != c - 144)) bad++;
            if ((c > 200) && (c < 784) && s_mem_we) we_seen++;
            if (c == 201) check("active_wr_ready_low", s_wr_ready, 1'b0);
            if (c == 784) check("active_drain", {s_mem_we, s_mem_addr, s_mem_wdata},
                                {1'b1, AW'(4321), 8'h5A});
            if (c == 785) check("active_wr_ready_back", s_wr_ready, 1'b1);
        end
        check("active_no_early_we", we_seen, 0);
        check("active_fetch_contiguous", bad, 0);

        // ---- reset at line 200 clock 300 with the buffer full
        adv_lines(200 - 101);
        for (int c = 0; c < 300; c++) begin
            tick(1'b0, c >= 144, c == 299, AW'(777), 8'h77);
        end
        check("midreset_buffer_full", wr_ready, 1'b0);
        do_reset(1'b1);

        // ---- two compressed frames from line 0 with random writes
        for (int f = 0; f < 2; f++) begin
            pv_cnt   = 0;
            vs_lines = 0;
            vd_lines = 0;
            fstart   = cyc;
            for (int l = 0; l < LINES; l++) begin
                for (int c = 0; c < S_LINE; c++) begin
                    rv = ($urandom_range(0, 2) == 0);
                    ra = ($urandom_range(0, 9) == 0) ? AW'(FB_WORDS + $urandom_range(0, 100))
                                                     : AW'($urandom_range(0, FB_WORDS - 1));
                    rd = PIXW'($urandom);
                    tick(c == S_LINE - 1, (c >= S_HS) && (c < S_HS + S_HACT), rv, ra, rd);
                    if (s_pixel_valid) pv_cnt++;
                    if (s_frame_tic) tics.push_back(cyc - 1 - fstart);
                    if (c == 0) begin
                        if (!s_vsync_n) vs_lines++;
                        if (s_vdisplay) vd_lines++;
                    end
                    if ((l == 35) && (c == S_HS)) begin
                        check("first_fetch_addr", {s_vdisplay, s_mem_we ? 1'b1 : 1'b0, s_mem_addr},
                              {1'b1, s_mem_we ? 1'b1 : 1'b0, s_mem_we ? s_mem_addr : AW'(0)});
                    end
                    if ((l == 35) && (c == S_HS + 1)) check("first_pixel_valid", s_pixel_valid, 1'b1);
                    if ((l == 34) && (c == S_HS + 1)) check("no_pixel_before_35", s_pixel_valid, 1'b0);
                end
            end
            check($sformatf("frame%0d_pixels", f), pv_cnt, 480 * S_HACT);
            check($sformatf("frame%0d_vsync_lines", f), vs_lines, 2);
            check($sformatf("frame%0d_vdisplay_lines", f), vd_lines, 480);
            check($sformatf("frame%0d_tic_count", f), tics.size(), 1);
            if (tics.size() > 0) begin
                check($sformatf("frame%0d_tic_pos", f), tics[0], LINES * S_LINE - 1);
            end
            tics.delete();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_frame_scheduler.md
# vga_frame_scheduler

- Sequences the 640x480 VGA frame one level above the horizontal sync generator.
- Counts lines from the horizontal `linetic` pulse and produces vertical sync, `Vdisplay` and a frame tick.
- Shares a single-port synchronous frame-buffer RAM between display scan-out and a pixel writer. Scan-out always wins; writes drain through a one-entry buffer in any cycle without a pixel fetch.

## Interface
- `PIXW`, default 8: pixel data width.
- `AW`, default 19: frame-buffer address width; 640*480 = 307200 words.
- `inputclk` in 1: pixel clock, 25 MHz domain shared with the horizontal sync generator.
- `reset_b` in 1: asynchronous, active-high reset.
- `linetic` in 1: one-cycle pulse on the last clock of each 800-clock line.
- `Hdisplay` in 1: high during the 640 active pixels of a line.
- `wr_valid` in 1: writer holds a pixel for the buffer.
- `wr_addr` in AW: write address.
- `wr_data` in PIXW: write data.
- `wr_ready` out 1: one-entry write buffer is empty.
- `wr_err` out 1: one-cycle pulse when an accepted write is dropped.
- `vsync_n` out 1: vertical sync, active low.
- `Vdisplay` out 1: current line is an active display line.
- `frame_tic` out 1: one-cycle pulse on the last clock of the frame.
- `mem_addr` out AW: RAM address.
- `mem_we` out 1: RAM write enable.
- `mem_wdata` out PIXW: RAM write data.
- `pixel_valid` out 1: RAM read data is a display pixel this cycle.

## Operation
- **Line counter `vcount`** (10 bits, reset 0)
  - Increments on `linetic`; value 524 with `linetic` wraps to 0.
  - `frame_tic = linetic & (vcount == 524)`.
- **Decodes** (combinational from `vcount`)
  - `vsync_n = ~(vcount < 2)`.
  - `Vdisplay = (vcount >= 35) & (vcount < 515)`.
- **Fetch**
  - `fetch = Hdisplay & Vdisplay`.
  - Pixel address register `pix_addr` (AW bits, reset 0): increments by 1 on each fetch cycle; cleared to 0 on `frame_tic`.
  - After 307200 fetches it reads 307200; no further fetches occur in that frame.
- **Write buffer** (`buf_full`, `buf_addr`, `buf_data`)
  - `wr_ready = ~buf_full`.
  - Accept: `wr_valid & wr_ready` loads the buffer and sets `buf_full` on the next edge.
  - No same-cycle accept and drain, so peak throughput is one write per 2 cycles.
- **Write buffer states**
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain: `buf_full & ~fetch` and `buf_addr < 307200`. In the drain cycle: `mem_we = 1`, `mem_addr = buf_addr`, `mem_wdata = buf_data`.
  - FULL -> EMPTY on drop: `buf_full & ~fetch` and `buf_addr >= 307200`. In the drop cycle: `mem_we = 0`, `wr_err = 1`.
  - FULL with `fetch` = 1: stalls; the buffer holds its contents.
- **RAM port mux**
  - Without a drain: `mem_addr = pix_addr`, `mem_we = 0`, `mem_wdata = buf_data`.
  - A fetch and a drain never share a cycle.
- **`pixel_valid`**: registered copy of `fetch` (RAM read latency 1); reset 0.
- **Reset**, asserted at any time including mid-line or mid-write:
  - `vcount = 0`, `pix_addr = 0`, buffer EMPTY (contents discarded, no write issued), `pixel_valid = 0`.
  - Hence `vsync_n = 0`, `Vdisplay = 0`, `frame_tic = 0`, `wr_ready = 1`, `wr_err = 0`, `mem_we = 0`, `mem_addr = 0`.

## Timing
- Fetch address is presented in the same cycle `Hdisplay & Vdisplay` is high.
- Pixel data is valid one cycle later, qualified by `pixel_valid`.
- Write latency:
  - Accept edge, then drain in the first following cycle with `fetch` = 0.
  - Best case: drain one cycle after accept.
  - Worst case inside an active line: 640 cycles + 1.
- Writes are never starved across a line: at least 160 non-fetch cycles occur per line.
- `linetic` and `Hdisplay` are never both high; `vcount` changes only outside fetch cycles.
- `vcount` and `pix_addr` update on the edge that ends the `linetic` cycle.
- `frame_tic`, `Vdisplay` and `vsync_n` are combinational from registered state and `linetic`; no glitch requirement beyond synchronous use.

## Test plan
- **Reset, then free-run**
  - Stimulus: release reset; free-run a horizontal stimulus (800-clock lines, `Hdisplay` on clocks 144..783).
  - Required: `vsync_n` low for lines 0-1.
  - Required: `Vdisplay` high for lines 35-514.
  - Required: `frame_tic` pulses every 420000 clocks.
- **Scan-out across a frame**
  - Required: 307200 `pixel_valid` cycles per frame.
  - Required: `mem_addr` runs 0..307199 in order during fetch.
  - Required: first fetch at line 35, clock 144, with `mem_addr = 0`.
- **Write during blanking**
  - Stimulus: `wr_valid` with `wr_addr = 1234`, `wr_data = 8'hA5` at line 10.
  - Required: `wr_ready` drops next cycle.
  - Required: one cycle later `mem_we = 1`, `mem_addr = 1234`, `mem_wdata = A5`.
  - Required: `wr_ready` back to 1 the cycle after.
- **Write during active pixels**
  - Stimulus: write accepted at line 100, clock 200.
  - Required: no `mem_we` until clock 784.
  - Required: fetch addresses stay contiguous.
  - Required: drain at clock 784 with the correct address and data.
- **Out-of-range write**
  - Stimulus: `wr_addr = 307200`.
  - Required: `wr_err` pulses once; `mem_we` stays 0; buffer empties.
- **Reset mid-operation**
  - Stimulus: reset while the buffer is full at line 200, clock 300.
  - Required: no write issued; all outputs at reset values.
  - Required: the frame restarts from line 0 with `pix_addr = 0`.
